// File: rtl/sr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger, echo wait, echo width to cm, holdoff.
// Define SR04_ECHO_SYNC_EN to put a 2-flop synchronizer on i_echo.
`timescale 1ns/1ps
module sr04_ctrl #(
  parameter int TRIG_US    = 11,
  parameter int WAIT_TO_US = 30000,
  parameter int ECHO_TO_US = 25000,
  parameter int HOLDOFF_US = 60000,
  parameter int US_PER_CM  = 58,
  parameter int DIST_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_echo,
  output logic              o_trig,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DIST_W-1:0] o_dist
);

  localparam int SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(WAIT_TO_US - 1);
  localparam logic [15:0]      ECHO_LAST = 16'(ECHO_TO_US - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(US_PER_CM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_DONE,
    S_ERR,
    S_HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        t_cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic [DIST_W-1:0]  cm_cnt;
  logic               echo_in;
  logic               echo_s;
  logic               echo_q;
  logic               rise;
  logic               fall;

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef SR04_ECHO_SYNC_EN
  logic echo_p0;
  logic echo_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
    end else begin
      echo_p0 <= i_echo;
      echo_p1 <= echo_p0;
    end
  end

  assign echo_in = echo_p1;
`else
  assign echo_in = i_echo;
`endif

  // edge-detect stage: echo_s is the internal echo, echo_q its previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      echo_s <= echo_in;
      echo_q <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_q;
  assign fall = ~echo_s & echo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // fall is tested before the echo timeout so it wins a same-clk tie
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_TRIG;
      S_TRIG: if (i_tick && t_cnt == TRIG_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (rise)                               state_nxt = S_MEAS;
        else if (i_tick && t_cnt == WAIT_LAST)  state_nxt = S_ERR;
      end
      S_MEAS: begin
        if (fall)                               state_nxt = S_DONE;
        else if (i_tick && t_cnt == ECHO_LAST)  state_nxt = S_ERR;
      end
      S_DONE: state_nxt = S_HOLD;
      S_ERR:  state_nxt = S_HOLD;
      S_HOLD: if (i_tick && t_cnt == HOLD_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     t_cnt <= '0;
    else if (state_nxt != state) t_cnt <= '0;
    else if (i_tick)             t_cnt <= t_cnt + 16'd1;
  end

  // running divide: one cm per US_PER_CM echo ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (state == S_IDLE) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (state == S_MEAS && i_tick && echo_s) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        cm_cnt  <= sat_inc(cm_cnt);
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_trig <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_dist <= '0;
    end else begin
      o_trig <= (state_nxt == S_TRIG);
      o_busy <= (state_nxt != S_IDLE);
      o_done <= (state == S_DONE);
      o_err  <= (state == S_ERR);
      if (state == S_DONE) o_dist <= cm_cnt;
    end
  end

endmodule

// File: doc/sr04_ctrl.md
# sr04_ctrl

Measurement sequencer for the HC-SR04 ultrasonic ranger. It runs on the system clock and uses the 1 MHz tick from the tick generator as its only time base. On each start request it issues the trigger pulse, waits for the echo, and measures the echo width in microseconds. It converts that width to centimetres with a running divide-by-58 and enforces the sensor's inter-measurement holdoff. The watch display and FND logic read `o_dist` from it.

## Interface
- `TRIG_US`, 11: trigger length in ticks. The pulse is always at least 10 µs.
- `WAIT_TO_US`, 30_000: maximum number of ticks from trigger end to echo rise.
- `ECHO_TO_US`, 25_000: maximum echo-high length in ticks.
- `HOLDOFF_US`, 60_000: dead time after DONE or ERR, in ticks.
- `US_PER_CM`, 58: echo ticks per centimetre.
- `DIST_W`, 9: distance width.
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_tick`, in, 1: one-clk pulse at 1 MHz.
- `i_start`, in, 1: measurement request, one clk or longer.
- `i_echo`, in, 1: sensor ECHO pin, asynchronous.
- `o_trig`, out, 1: sensor TRIG pin, registered.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-clk pulse when a valid distance is latched.
- `o_err`, out, 1: one-clk pulse on timeout.
- `o_dist`, out, DIST_W: last valid distance in cm.

## Operation
- Reset value of every output is 0. The state is IDLE and all counters are 0.
- Internal counters:
  - `t_cnt`: 16 bits, cleared on every state entry, incremented on each `i_tick`.
  - `sub_cnt`: 0..US_PER_CM-1.
  - `cm_cnt`: DIST_W bits.
- `echo_s` is the echo as used internally. `rise` and `fall` are detected per clk from `echo_s` against its previous value.
- **IDLE**: `i_start`=1 moves to TRIG. `sub_cnt` and `cm_cnt` are cleared.
- **TRIG**: `o_trig`=1. On the `i_tick` where `t_cnt`==TRIG_US-1, move to WAIT_ECHO.
- **WAIT_ECHO**: `rise` moves to MEASURE. If instead `i_tick` arrives with `t_cnt`==WAIT_TO_US-1, move to ERR.
- **MEASURE**: on each `i_tick` with `echo_s`=1:
  - `sub_cnt` increments. When it reaches US_PER_CM-1 it wraps to 0 and `cm_cnt` increments.
  - `cm_cnt` saturates at 2^DIST_W-1.
  - The result is `cm_cnt` = floor(echo_ticks / US_PER_CM).
  - `fall` moves to DONE.
  - `i_tick` with `t_cnt`==ECHO_TO_US-1 moves to ERR.
  - If `fall` and the timeout occur in the same clk, `fall` wins.
- **DONE**: one clk. `o_dist` takes `cm_cnt` and `o_done` pulses. Then move to HOLD.
- **ERR**: one clk. `o_err` pulses and `o_dist` is unchanged. Then move to HOLD.
- **HOLD**: on the `i_tick` where `t_cnt`==HOLDOFF_US-1, move to IDLE.
- `i_start` is ignored in every state other than IDLE. It is not queued.
- A held-high `i_start` retriggers right after HOLD ends.

## Timing
- Outputs change only on `clk` rising edges, apart from the asynchronous reset.
- `i_start` sampled in IDLE makes `o_trig` and `o_busy` rise 1 clk later.
- `o_trig` width is between (TRIG_US-1) and TRIG_US µs, depending on tick phase. With the default it lies in the range 10..11 µs.
- Echo rise or fall at the pin reaches `rise`/`fall` after the synchronizer latency (see Configuration).
- DONE is entered 1 clk after `fall`. `o_done` and the new `o_dist` are both visible on the clk after DONE is entered.
- `o_done` and `o_err` are never high in the same clk.
- `o_busy` drops in the clk IDLE is re-entered.
- Asynchronous `rst` at any point forces IDLE immediately:
  - `o_trig`=0, `o_dist`=0.
  - No `o_done` or `o_err` pulse is produced.

## Configuration
- `SR04_ECHO_SYNC_EN` defined:
  - `i_echo` passes through a 2-flop synchronizer (reset value 0) before edge detection.
  - Pin-to-`rise`/`fall` latency is 3 clk.
- Not defined:
  - `i_echo` feeds the edge-detect register directly. The pin must already be synchronous.
  - Pin-to-`rise`/`fall` latency is 1 clk.
- Measured distance is identical in both builds. The synchronizer delays rise and fall by the same amount.

## Test plan
All scenarios use `clk` 100 MHz and `i_tick` every 100 clk.

- Start, echo rise 200 µs after trigger, echo high 580 µs -> `o_trig` 10–11 µs wide, `o_done` pulses once, `o_dist`=10, `o_busy` low 60 ms later.
- Echo held high 57 µs, then in a second measurement 58 µs -> `o_dist`=0, then `o_dist`=1 (divide boundary).
- Echo never rises -> `o_err` pulses exactly 30_000 ticks after trigger end, `o_dist` keeps its previous value, HOLD follows.
- Echo stuck high -> `o_err` after 25_000 ticks in MEASURE, no `o_done`.
- `i_start` pulsed during TRIG, MEASURE and HOLD -> ignored, exactly one measurement completes. `i_start` held high -> the next TRIG starts 1 clk after IDLE is reached.
- `rst` asserted mid-MEASURE -> `o_trig`=0, `o_busy`=0, `o_dist`=0 immediately. After release, a 1160 µs echo gives `o_dist`=20.
